// File: rtl/mil1553_tx_encoder.sv
// -----------------------------------------------------------------------------
// mil1553_tx_encoder
//
// Manchester II word transmitter for the MIL-STD-1553 transmit path. Words are
// accepted over a valid/ready handshake into a one-entry holding register and
// then shifted onto the bus as a 20-bit-time word: 3-bit-time sync, 16 data
// bits (MSB first) and an odd parity bit. Each bit time is two half-bits of
// HALF_BIT_CYCLES clocks. Words queued during a transmission follow with no
// gap on the bus.
//
// Parameters:
//   HALF_BIT_CYCLES  clocks per Manchester half-bit (>= 2)
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset, aborts any word in flight
//   i_valid       word offered
//   o_ready       holding register empty
//   i_data        16-bit payload, MSB transmitted first
//   i_sync_cmd    1 = command/status sync, 0 = data sync
//   i_inj_parity  (MIL1553_TX_PARITY_INJECT_EN only) invert the parity bit
//   o_tx_p        bus positive drive
//   o_tx_n        bus negative drive (complement of o_tx_p while enabled)
//   o_tx_en       transceiver enable, high while a word is on the bus
//   o_busy        word shifting or held
//   o_done        one-cycle pulse on the final cycle of each word
//
// Build option:
//   MIL1553_TX_PARITY_INJECT_EN  adds i_inj_parity for deliberate parity
//                                errors used in bus-monitor testing.
// -----------------------------------------------------------------------------
module mil1553_tx_encoder #(
  parameter int HALF_BIT_CYCLES = 50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_data,
  input  logic        i_sync_cmd,
`ifdef MIL1553_TX_PARITY_INJECT_EN
  input  logic        i_inj_parity,
`endif
  output logic        o_tx_p,
  output logic        o_tx_n,
  output logic        o_tx_en,
  output logic        o_busy,
  output logic        o_done
);

  localparam int            CW             = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST       = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [5:0]    HALF_SYNC_LAST = 6'd5;
  localparam logic [5:0]    HALF_DATA_LAST = 6'd37;
  localparam logic [5:0]    HALF_WORD_LAST = 6'd39;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [5:0]    half, half_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic          cmd, cmd_nxt;
  logic          par, par_nxt;

  logic          hold_valid, hold_valid_nxt;
  logic [15:0]   hold_data;
  logic          hold_cmd;
  logic          hold_par;

  logic          accept;
  logic          load;
  logic          capt_par;
  logic          level_nxt;
  logic          done_nxt;

  assign accept = i_valid & o_ready;

  // Parity is odd over data plus parity, so it is the inverted XOR of the data.
`ifdef MIL1553_TX_PARITY_INJECT_EN
  assign capt_par = ~(^i_data) ^ i_inj_parity;
`else
  assign capt_par = ~(^i_data);
`endif

  // The engine frees the holding register when it loads from it; a new
  // handshake on that same cycle lands in the freed entry.
  assign hold_valid_nxt = accept | (hold_valid & ~load);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_cmd   <= 1'b0;
      hold_par   <= 1'b0;
    end else begin
      hold_valid <= hold_valid_nxt;
      if (accept) begin
        hold_data <= i_data;
        hold_cmd  <= i_sync_cmd;
        hold_par  <= capt_par;
      end
    end
  end

  // Shift engine state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cyc   <= '0;
      half  <= '0;
      shreg <= '0;
      cmd   <= 1'b0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
      half  <= half_nxt;
      shreg <= shreg_nxt;
      cmd   <= cmd_nxt;
      par   <= par_nxt;
    end
  end

  // Next-state logic. half counts half-bits across the whole word (0..39);
  // the data register shifts after the second half of each data bit so
  // shreg[15] is always the bit currently on the bus.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    half_nxt  = half;
    shreg_nxt = shreg;
    cmd_nxt   = cmd;
    par_nxt   = par;
    load      = 1'b0;

    case (state)
      IDLE: begin
        if (hold_valid) load = 1'b1;
      end
      default: begin
        if (cyc == CYC_LAST) begin
          cyc_nxt  = '0;
          half_nxt = half + 6'd1;
          if (state == DATA && half[0]) shreg_nxt = {shreg[14:0], 1'b0};
          if (half == HALF_SYNC_LAST) begin
            state_nxt = DATA;
          end else if (half == HALF_DATA_LAST) begin
            state_nxt = PARITY;
          end else if (half == HALF_WORD_LAST) begin
            half_nxt = '0;
            if (hold_valid) load = 1'b1;
            else            state_nxt = IDLE;
          end
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
      end
    endcase

    if (load) begin
      state_nxt = SYNC;
      cyc_nxt   = '0;
      half_nxt  = '0;
      shreg_nxt = hold_data;
      cmd_nxt   = hold_cmd;
      par_nxt   = hold_par;
    end
  end

  // Bus level for the upcoming cycle. Even half-bit indices are the first
  // half of a bit (sync occupies 0..5), so a bit value shows unchanged on the
  // even half and inverted on the odd half.
  always_comb begin
    level_nxt = 1'b0;
    case (state_nxt)
      SYNC:    level_nxt = (half_nxt < 6'd3) ? cmd_nxt : ~cmd_nxt;
      DATA:    level_nxt = shreg_nxt[15] ^ half_nxt[0];
      PARITY:  level_nxt = par_nxt ^ half_nxt[0];
      default: level_nxt = 1'b0;
    endcase
    done_nxt = (state_nxt == PARITY) && (half_nxt == HALF_WORD_LAST) &&
               (cyc_nxt == CYC_LAST);
  end

  // All outputs are registered from the next-state values so they line up
  // with the engine position of the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready <= 1'b1;
      o_tx_p  <= 1'b0;
      o_tx_n  <= 1'b0;
      o_tx_en <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_ready <= ~hold_valid_nxt;
      o_tx_en <= (state_nxt != IDLE);
      o_tx_p  <= (state_nxt != IDLE) & level_nxt;
      o_tx_n  <= (state_nxt != IDLE) & ~level_nxt;
      o_busy  <= (state_nxt != IDLE) | hold_valid_nxt;
      o_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mil1553_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_mil1553_tx_encoder
//
// Scoreboard bench for mil1553_tx_encoder with HALF_BIT_CYCLES = 4 (one word
// = 160 clocks). Every accepted word pushes its expected 160-cycle o_tx_p
// waveform into a queue; a monitor captures each word as it appears on the
// bus and compares p, n, enable and done against the popped entry. Directed
// sequences cover single words, back-to-back words, backpressure, reset in
// mid-word and, when MIL1553_TX_PARITY_INJECT_EN is defined, parity injection.
// -----------------------------------------------------------------------------
module tb_mil1553_tx_encoder;

  localparam int HALF = 4;
  localparam int WLEN = 40 * HALF;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic        oReady;
  logic [15:0] iData;
  logic        iSyncCmd;
`ifdef MIL1553_TX_PARITY_INJECT_EN
  logic        iInjParity;
`endif
  logic        oTxP;
  logic        oTxN;
  logic        oTxEn;
  logic        oBusy;
  logic        oDone;

  mil1553_tx_encoder #(.HALF_BIT_CYCLES(HALF)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (iValid),
    .o_ready      (oReady),
    .i_data       (iData),
    .i_sync_cmd   (iSyncCmd),
`ifdef MIL1553_TX_PARITY_INJECT_EN
    .i_inj_parity (iInjParity),
`endif
    .o_tx_p       (oTxP),
    .o_tx_n       (oTxN),
    .o_tx_en      (oTxEn),
    .o_busy       (oBusy),
    .o_done       (oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard and monitor state.
  logic [WLEN-1:0] expQ[$];
  int              startCycles[$];
  int              doneCycles[$];
  int              cycNow       = 0;
  int              wordsDone    = 0;
  int              pos          = 0;
  bit              inWord       = 1'b0;
  bit              abortPending = 1'b0;
  bit              quietBad     = 1'b0;
  logic [WLEN-1:0] curExp, obsP, obsN, obsE, obsD;

  task automatic checkOutput(input string tag, input logic [WLEN-1:0] got,
                             input logic [WLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference waveform: sync, 16 Manchester data bits MSB first, odd parity.
  function automatic logic [WLEN-1:0] buildWave(input logic [15:0] d,
                                                 input logic c, input logic inj);
    logic [39:0]     hb;
    logic [WLEN-1:0] w;
    logic            p;
    p = ~(^d) ^ inj;
    hb[39:34] = c ? 6'b111000 : 6'b000111;
    for (int b = 0; b < 16; b++) hb[33-2*b -: 2] = d[15-b] ? 2'b10 : 2'b01;
    hb[1:0] = p ? 2'b10 : 2'b01;
    w = '0;
    for (int i = 0; i < 40; i++)
      for (int k = 0; k < HALF; k++) w[WLEN-1-HALF*i-k] = hb[39-i];
    return w;
  endfunction

  // Bus monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cycNow = cycNow + 1;
    if (oDone === 1'b1) doneCycles.push_back(cycNow);
    if (abortPending) begin
      inWord       = 1'b0;
      abortPending = 1'b0;
    end
    if (!inWord) begin
      if (oTxEn === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 1, 0);
          curExp = '0;
        end else begin
          curExp = expQ.pop_front();
        end
        inWord = 1'b1;
        pos    = 0;
        obsP   = '0;
        obsN   = '0;
        obsE   = '0;
        obsD   = '0;
        startCycles.push_back(cycNow);
      end else if ((oTxP | oTxN | oDone) === 1'b1) begin
        quietBad = 1'b1;
      end
    end
    if (inWord) begin
      obsP[WLEN-1-pos] = oTxP;
      obsN[WLEN-1-pos] = oTxN;
      obsE[WLEN-1-pos] = oTxEn;
      obsD[WLEN-1-pos] = oDone;
      pos++;
      if (pos == WLEN) begin
        checkOutput("word_tx_p", obsP, curExp);
        checkOutput("word_tx_n", obsN, ~curExp);
        checkOutput("word_tx_en", obsE, {WLEN{1'b1}});
        checkOutput("word_done", obsD, WLEN'(1));
        inWord = 1'b0;
        wordsDone++;
      end
    end
  end

  // Offers one word at a negedge, holding i_valid until o_ready allows the
  // handshake. Returns the handshake cycle and leaves at the following negedge.
  task automatic applyStimulus(input logic [15:0] d, input logic c,
                               input logic inj, output int hsCycle);
    int budget;
    budget   = 0;
    iValid   = 1'b1;
    iData    = d;
    iSyncCmd = c;
`ifdef MIL1553_TX_PARITY_INJECT_EN
    iInjParity = inj;
`endif
    while (oReady !== 1'b1 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (oReady !== 1'b1) begin
      checkOutput("ready_timeout", 0, 1);
      iValid  = 1'b0;
      hsCycle = 0;
      return;
    end
    hsCycle = cycNow;
    expQ.push_back(buildWave(d, c, inj));
    @(negedge clk);
    iValid   = 1'b0;
    iData    = 16'($urandom);
    iSyncCmd = 1'($urandom);
`ifdef MIL1553_TX_PARITY_INJECT_EN
    iInjParity = 1'($urandom);
`endif
    checkOutput("hs_ready_busy", {oReady, oBusy}, 2'b01);
  endtask

  task automatic waitWords(input int n);
    int budget;
    budget = 0;
    while (wordsDone < n && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("word_count", wordsDone, n);
  endtask

  int h1, h2, h3, sBase, dBase;

  initial begin
    rst      = 1'b1;
    iValid   = 1'b0;
    iData    = '0;
    iSyncCmd = 1'b0;
`ifdef MIL1553_TX_PARITY_INJECT_EN
    iInjParity = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_state", {oReady, oTxP, oTxN, oTxEn, oBusy, oDone}, 6'b100000);

    // Single command word, all zero data.
    applyStimulus(16'h0000, 1'b1, 1'b0, h1);
    @(negedge clk);
    checkOutput("first_sync", {oReady, oTxEn, oTxP, oTxN, oBusy}, 5'b11101);
    waitWords(1);
    checkOutput("single_start", startCycles[startCycles.size()-1], h1 + 2);
    checkOutput("single_done", doneCycles[doneCycles.size()-1], h1 + 161);
    @(negedge clk);
    checkOutput("single_idle", {oTxEn, oBusy, oTxP, oTxN, oReady}, 5'b00001);

    // Data word, all ones.
    repeat (5) @(negedge clk);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, h1);
    waitWords(2);
    checkOutput("data_start", startCycles[startCycles.size()-1], h1 + 2);

    // Back-to-back: a data word queued 10 cycles into a command word.
    repeat (7) @(negedge clk);
    sBase = startCycles.size();
    dBase = doneCycles.size();
    applyStimulus(16'hC3E1, 1'b1, 1'b0, h1);
    while (cycNow < h1 + 10) @(negedge clk);
    applyStimulus(16'hA5A5, 1'b0, 1'b0, h2);
    waitWords(4);
    checkOutput("b2b_start2", startCycles[sBase+1], h1 + 162);
    checkOutput("b2b_done_count", doneCycles.size() - dBase, 2);
    checkOutput("b2b_done1", doneCycles[dBase], h1 + 161);
    checkOutput("b2b_done2", doneCycles[dBase+1], h1 + 321);
    @(negedge clk);
    checkOutput("b2b_idle", {oTxEn, oBusy}, 2'b00);

    // Backpressure: third word must wait until the engine takes the second.
    repeat (4) @(negedge clk);
    applyStimulus(16'h0001, 1'b1, 1'b0, h1);
    applyStimulus(16'h8000, 1'b0, 1'b0, h2);
    applyStimulus(16'h7FFE, 1'b1, 1'b0, h3);
    checkOutput("bp_hs2", h2, h1 + 2);
    checkOutput("bp_hs3", h3, h1 + 162);
    waitWords(7);

    // Reset in mid-word with a second word queued.
    repeat (6) @(negedge clk);
    applyStimulus(16'h3C3C, 1'b1, 1'b0, h1);
    applyStimulus(16'h0F0F, 1'b0, 1'b0, h2);
    while (cycNow < h1 + 50) @(negedge clk);
    rst          = 1'b1;
    abortPending = 1'b1;
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_outputs", {oReady, oTxP, oTxN, oTxEn, oBusy, oDone}, 6'b100000);
    sBase = startCycles.size();
    dBase = doneCycles.size();
    repeat (400) @(negedge clk);
    checkOutput("abort_no_word", startCycles.size(), sBase);
    checkOutput("abort_no_done", doneCycles.size(), dBase);
    checkOutput("abort_words", wordsDone, 7);

`ifdef MIL1553_TX_PARITY_INJECT_EN
    // Injected parity: 0x0001 has correct parity 0, transmitted as 1.
    applyStimulus(16'h0001, 1'b0, 1'b1, h1);
    waitWords(8);
`endif

    repeat (5) @(negedge clk);
    checkOutput("bus_quiet", quietBad, 0);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mil1553_tx_encoder.md
# mil1553_tx_encoder

Manchester II word transmitter for the MIL-STD-1553 transmit path. It accepts 16-bit words over a valid/ready handshake and emits the 20-bit-time bus word: a 3-bit-time sync, 16 data bits and odd parity. The word drives complementary transceiver outputs with a transmit-enable. It sits between the message sequencer and the external transceiver, mirroring the receive path, which conditions the incoming bus signals.

## Interface
- HALF_BIT_CYCLES, 50, i_clk cycles per Manchester half-bit (500 ns at 100 MHz); legal range ≥ 2
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_valid  in  1  word offered
- o_ready  out  1  holding register empty; a word is accepted on any cycle with i_valid & o_ready
- i_data  in  16  word payload, MSB transmitted first
- i_sync_cmd  in  1  1 = command/status sync, 0 = data sync; captured with i_data
- o_tx_p  out  1  bus positive drive
- o_tx_n  out  1  bus negative drive
- o_tx_en  out  1  transceiver enable, high while any word is on the bus
- o_busy  out  1  high while a word is shifting or one is held
- o_done  out  1  one-cycle pulse on the final cycle of each word

## Operation
- Structure: a one-entry holding register (word, sync type, parity) feeds a shift engine. o_ready = ~hold_valid.
- States:
  - IDLE: the engine loads from the holding register on the cycle after hold_valid is seen.
  - SYNC: 6 half-bits.
  - DATA: 32 half-bits.
  - PARITY: 2 half-bits.
- Sync levels on o_tx_p:
  - Command sync: high 3 half-bits, then low 3 half-bits.
  - Data sync: low 3 half-bits, then high 3 half-bits.
- Data and parity bits: a 1 is high then low; a 0 is low then high.
- Parity is odd over the 16 data bits plus parity: parity = ~^i_data, computed at capture.
- While o_tx_en = 1, o_tx_n = ~o_tx_p. While o_tx_en = 0, both are 0 (bus quiescent).
- Counters:
  - Cycle counter: width $clog2(HALF_BIT_CYCLES), wraps at HALF_BIT_CYCLES-1.
  - Half-bit index: 6 bits, 0..39.
- Back-to-back operation: if hold_valid is set when half-bit 39 ends, the next word's sync starts on the very next cycle. There is no gap and o_tx_en stays high. Otherwise the engine returns to IDLE and o_tx_en drops.
- The holding register frees (o_ready=1) the cycle after the engine loads it. Up to one word can therefore be queued during transmission.
- A handshake on the same cycle the engine loads is legal. The new word lands in the now-freed register.
- Reset values: o_ready=1, o_tx_p=0, o_tx_n=0, o_tx_en=0, o_busy=0, o_done=0. Holding register and counters are cleared.
- Reset mid-word aborts immediately. Outputs take their reset values on the first clock edge with i_rst high, o_done does not pulse, and the queued word is discarded.

## Timing
- All outputs are registered.
- If a handshake occurs on cycle 0 with the engine idle:
  - o_ready is low on cycle 1.
  - Cycle 2: first sync level, o_tx_en=1, o_busy=1.
  - The word occupies cycles 2 .. 2+40·HALF_BIT_CYCLES-1.
  - o_done is high on the last of those cycles.
  - o_ready returns high on cycle 2.
- i_data and i_sync_cmd are sampled only on the handshake cycle and may change afterward.
- i_valid held with o_ready low: no capture. The master holds the data stable.

## Configuration
- MIL1553_TX_PARITY_INJECT_EN defined:
  - Adds input i_inj_parity (1 bit), captured with i_data.
  - When it is 1, the transmitted parity bit is inverted, for bus-monitor error testing.
- Undefined: the port is absent and parity is always odd.

## Test plan
(All with HALF_BIT_CYCLES=4; one word = 160 cycles.)
- Single command word: handshake at cycle 0 with i_data=0x0000, i_sync_cmd=1.
  - o_tx_p high cycles 2–13, low 14–25.
  - Sixteen "0" bits (low 4, high 4 each).
  - Parity "1" on cycles 154–161 (high 4, low 4).
  - o_done pulse at cycle 161; o_tx_en low at 162.
- Data word: i_data=0xFFFF, i_sync_cmd=0.
  - o_tx_p low 12, high 12.
  - Sixteen "1" bits; parity bit = 1.
  - o_tx_n is the exact complement throughout.
- Back-to-back: 0xA5A5 data sync queued at cycle 10 during a command word.
  - Second sync begins at cycle 162; o_tx_en is continuous for 320 cycles.
  - Two o_done pulses at 161 and 321.
- Backpressure: i_valid held while o_ready=0 with a third word.
  - No capture until o_ready rises; exactly three words are transmitted, in order.
- Reset mid-word: i_rst high for 1 cycle at cycle 50 with a word queued.
  - From cycle 51 all outputs are at reset values and o_ready=1.
  - No o_done pulse; the queued word is never sent.
- With MIL1553_TX_PARITY_INJECT_EN: 0x0001 sent with i_inj_parity=1 → transmitted parity bit = 1 (correct value 0).
